soft_start_ramp: RTL and testbench

Parametrised successor to the fixed-constant soft-start block. Ramps the PWM duty select from zero towards a run-time target in configurable steps, one step every N switching periods. It then holds the target and follows later target changes at the same slew rate. When enable drops, it performs a soft stop, ramping down to zero before releasing the power stage. It sits between the control/config registers and the PWM generator's duty-select input.

---
 rtl/smps_pkg.sv | 35 +++
 rtl/period_tick.sv | 42 ++++
 rtl/soft_start_ramp.sv | 146 ++++++++++++++
 tb/tb_soft_start_ramp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smps_pkg.sv
// Shared types and helpers for the switching-supply control blocks.
package smps_pkg;

   // Default widths used by soft_start_ramp
   localparam int DEF_DUTY_W = 8;
   localparam int DEF_TS_W   = 10;
   localparam int DEF_CYC_W  = 7;

   // Working width of the saturating helpers; callers extend and truncate
   localparam int SAT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_t;

   // a + b, clamped to lim; the wide sum cannot wrap for realistic duty widths
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] lim);
      logic [SAT_W-1:0] sum;
      sum = a + b;
      return (sum > lim) ? lim : sum;
   endfunction

   // a - b, clamped from below to lo; never goes negative
   function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] lo);
      return (a >= lo + b) ? (a - b) : lo;
   endfunction

endpackage

// File: rtl/period_tick.sv
// Free-running interval counter: tick fires on the edge that completes
// 'per' enabled counts, then the count restarts. clr holds it at zero.
module period_tick #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] per,
   output logic         tick
);

   logic [W-1:0] cnt_reg;
   logic [W-1:0] cnt_next;
   logic         last;

   // Compared one bit wider so a count at all-ones cannot wrap; using >=
   // lets a shortened period take effect without overshooting
   assign last = ({1'b0, cnt_reg} + (W+1)'(1)) >= {1'b0, per};
   assign tick = en && !clr && last;

   // Next count: clear wins, otherwise advance and restart after the last count
   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (en) begin
         cnt_next = last ? '0 : cnt_reg + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/soft_start_ramp.sv
// Soft-start / soft-stop slew limiter for the PWM duty select. Moves the
// duty towards the target by one step every N switching periods.
module soft_start_ramp
   import smps_pkg::*;
#(
   parameter int DUTY_W = DEF_DUTY_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int CYC_W  = DEF_CYC_W
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              i_enable,
   input  logic [DUTY_W-1:0] i_target,
   input  logic [DUTY_W-1:0] i_step,
   input  logic [TS_W-1:0]   i_ts_period,
   input  logic [CYC_W-1:0]  i_cycles_per_step,
   output logic [DUTY_W-1:0] o_duty_sel,
   output logic              o_enable,
   output logic              o_done,
   output logic              o_idle,
   output logic              o_tick
);

   state_t            state_reg, state_next;
   logic [DUTY_W-1:0] duty_reg, duty_next;
   logic [TS_W-1:0]   per_reg;
   logic [CYC_W-1:0]  cps_reg;
   logic              tick_reg;

   logic              idle;
   logic              period_hit;
   logic              step_event;
   logic [DUTY_W-1:0] step_eff;
   logic [TS_W-1:0]   per_eff;
   logic [CYC_W-1:0]  cps_eff;
   logic [DUTY_W-1:0] floor_val;
   logic [DUTY_W-1:0] up_val;
   logic [DUTY_W-1:0] dn_val;

   assign idle = (state_reg == ST_IDLE);

   // Zero in any config field means one
   assign step_eff = (i_step == '0)            ? DUTY_W'(1) : i_step;
   assign per_eff  = (i_ts_period == '0)       ? TS_W'(1)   : i_ts_period;
   assign cps_eff  = (i_cycles_per_step == '0) ? CYC_W'(1)  : i_cycles_per_step;

   // Ramp-down stops at the target while running, at zero for a soft stop
   assign floor_val = i_enable ? i_target : '0;
   assign up_val    = DUTY_W'(sat_add(SAT_W'(duty_reg), SAT_W'(step_eff), SAT_W'(i_target)));
   assign dn_val    = DUTY_W'(sat_sub(SAT_W'(duty_reg), SAT_W'(step_eff), SAT_W'(floor_val)));

   // Switching-period counter; runs whenever the block is active
   period_tick #(.W(TS_W)) u_period (
      .clk   (i_clk),
      .rst_n (reset),
      .clr   (idle),
      .en    (1'b1),
      .per   (per_reg),
      .tick  (period_hit)
   );

   // Periods-per-step counter; its tick is the step event
   period_tick #(.W(CYC_W)) u_step (
      .clk   (i_clk),
      .rst_n (reset),
      .clr   (idle),
      .en    (period_hit),
      .per   (cps_reg),
      .tick  (step_event)
   );

   // Next state and duty; target/enable comparisons run every clock,
   // duty only moves on a step event
   always_comb begin
      state_next = state_reg;
      duty_next  = duty_reg;
      case (state_reg)
         ST_IDLE: begin
            duty_next = '0;
            if (i_enable) state_next = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            if (!i_enable || (i_target < duty_reg)) begin
               state_next = ST_RAMP_DOWN;
            end else if (i_target == duty_reg) begin
               state_next = ST_HOLD;
            end else if (step_event) begin
               duty_next = up_val;
               if (up_val == i_target) state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!i_enable || (i_target < duty_reg)) begin
               state_next = ST_RAMP_DOWN;
            end else if (i_target > duty_reg) begin
               state_next = ST_RAMP_UP;
            end
         end
         ST_RAMP_DOWN: begin
            if (i_enable && (i_target > duty_reg)) begin
               state_next = ST_RAMP_UP;
            end else if (duty_reg == floor_val) begin
               state_next = i_enable ? ST_HOLD : ST_IDLE;
            end else if (step_event) begin
               duty_next = dn_val;
               if (dn_val == floor_val) state_next = i_enable ? ST_HOLD : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            duty_next  = '0;
         end
      endcase
   end

   // State, duty and registered period tick
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         duty_reg  <= '0;
         tick_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         duty_reg  <= duty_next;
         tick_reg  <= period_hit;
      end
   end

   // Period and cadence follow the inputs while idle, then only at step events
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         per_reg <= TS_W'(1);
         cps_reg <= CYC_W'(1);
      end else if (idle || step_event) begin
         per_reg <= per_eff;
         cps_reg <= cps_eff;
      end
   end

   assign o_duty_sel = duty_reg;
   assign o_enable   = (duty_reg != '0);
   assign o_done     = (state_reg == ST_HOLD);
   assign o_idle     = idle;
   assign o_tick     = tick_reg;

endmodule

// File: tb/tb_soft_start_ramp.sv
// Directed bench for soft_start_ramp: ramp timing, saturation, soft stop,
// re-enable, retargeting, reset mid-ramp and zero-config handling.
module tb_soft_start_ramp;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [7:0] target;
   logic [7:0] step_in;
   logic [9:0] ts_period;
   logic [6:0] cyc_per_step;
   logic [7:0] duty_sel;
   logic       pwr_en;
   logic       done;
   logic       idle;
   logic       tick;

   int total = 0;
   int bad   = 0;

   soft_start_ramp dut (
      .i_clk             (clk),
      .reset             (reset_n),
      .i_enable          (enable),
      .i_target          (target),
      .i_step            (step_in),
      .i_ts_period       (ts_period),
      .i_cycles_per_step (cyc_per_step),
      .o_duty_sel        (duty_sel),
      .o_enable          (pwr_en),
      .o_done            (done),
      .o_idle            (idle),
      .o_tick            (tick)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int p, input int n, input int s, input int t);
      ts_period    = 10'(p);
      cyc_per_step = 7'(n);
      step_in      = 8'(s);
      target       = 8'(t);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      cfg(0, 0, 0, 0);
      repeat (3) cyc();
      total++; if (duty_sel !== 8'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", duty_sel); end
      total++; if (idle !== 1'b1)     begin bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
      total++; if (pwr_en !== 1'b0)   begin bad++; $display("FAIL reset_enable: got %0b want 0", pwr_en); end
      total++; if (tick !== 1'b0)     begin bad++; $display("FAIL reset_tick: got %0b want 0", tick); end
      #2 reset_n = 1'b1;
      repeat (5) cyc();
      total++; if (idle !== 1'b1 || duty_sel !== 8'd0 || tick !== 1'b0) begin
         bad++; $display("FAIL idle_after_release: idle=%0b duty=%0d tick=%0b want 1/0/0", idle, duty_sel, tick);
      end
      $display("test_reset checked");
   endtask

   // P=10, N=5, step 1, target 4; j=0 is the edge that sees enable
   task automatic test_slow_ramp();
      int exp_d;
      cfg(10, 5, 1, 4);
      enable = 1'b1;
      for (int j = 0; j <= 205; j++) begin
         cyc();
         exp_d = (j >= 200) ? 4 : j / 50;
         total++; if (duty_sel !== 8'(exp_d)) begin bad++; $display("FAIL slow_duty j=%0d: got %0d want %0d", j, duty_sel, exp_d); end
         total++; if (done !== (j >= 200))   begin bad++; $display("FAIL slow_done j=%0d: got %0b want %0b", j, done, (j >= 200)); end
         total++; if (pwr_en !== (j >= 50))  begin bad++; $display("FAIL slow_enable j=%0d: got %0b want %0b", j, pwr_en, (j >= 50)); end
         total++; if (tick !== (j > 0 && j % 10 == 0)) begin
            bad++; $display("FAIL slow_tick j=%0d: got %0b want %0b", j, tick, (j > 0 && j % 10 == 0));
         end
         if (j % 50 == 0) $display("slow_ramp j=%0d duty=%0d done=%0b", j, duty_sel, done);
      end
   endtask

   // P=3, N=2 from idle: 64,128,192 then saturate at 200
   task automatic test_saturate();
      int exp_d;
      reset_n = 1'b0;
      enable  = 1'b0;
      #2 reset_n = 1'b1;
      cfg(3, 2, 64, 200);
      enable = 1'b1;
      for (int j = 0; j <= 26; j++) begin
         cyc();
         exp_d = 64 * (j / 6);
         if (exp_d > 200) exp_d = 200;
         total++; if (duty_sel !== 8'(exp_d)) begin bad++; $display("FAIL sat_duty j=%0d: got %0d want %0d", j, duty_sel, exp_d); end
         total++; if (done !== (j >= 24))     begin bad++; $display("FAIL sat_done j=%0d: got %0b want %0b", j, done, (j >= 24)); end
         if (j % 6 == 0) $display("saturate j=%0d duty=%0d", j, duty_sel);
      end
   endtask

   // From HOLD at 200, P=N=1, step 64: soft stop to idle
   task automatic test_soft_stop();
      int exp_d [5] = '{200, 136, 72, 8, 0};
      cfg(1, 1, 64, 200);
      repeat (8) cyc();
      total++; if (duty_sel !== 8'd200 || done !== 1'b1) begin
         bad++; $display("FAIL stop_pre: duty=%0d done=%0b want 200/1", duty_sel, done);
      end
      enable = 1'b0;
      for (int j = 0; j < 5; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(exp_d[j])) begin bad++; $display("FAIL stop_duty j=%0d: got %0d want %0d", j, duty_sel, exp_d[j]); end
         total++; if (pwr_en !== (j < 4))        begin bad++; $display("FAIL stop_enable j=%0d: got %0b want %0b", j, pwr_en, (j < 4)); end
         total++; if (idle !== (j == 4))         begin bad++; $display("FAIL stop_idle j=%0d: got %0b want %0b", j, idle, (j == 4)); end
         total++; if (done !== 1'b0)             begin bad++; $display("FAIL stop_done j=%0d: got %0b want 0", j, done); end
         $display("soft_stop j=%0d duty=%0d", j, duty_sel);
      end
   endtask

   // Ramp to 200, start a soft stop, re-enable at 72 and climb back
   task automatic test_reenable();
      int up_d [5] = '{0, 64, 128, 192, 200};
      int dn_d [3] = '{200, 136, 72};
      int re_d [3] = '{72, 136, 200};
      enable = 1'b1;
      for (int j = 0; j < 5; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(up_d[j])) begin bad++; $display("FAIL reen_up j=%0d: got %0d want %0d", j, duty_sel, up_d[j]); end
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL reen_hold: got %0b want 1", done); end
      enable = 1'b0;
      for (int j = 0; j < 3; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(dn_d[j])) begin bad++; $display("FAIL reen_down j=%0d: got %0d want %0d", j, duty_sel, dn_d[j]); end
      end
      enable = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(re_d[j])) begin bad++; $display("FAIL reen_climb j=%0d: got %0d want %0d", j, duty_sel, re_d[j]); end
         total++; if (done !== (j == 2))        begin bad++; $display("FAIL reen_done j=%0d: got %0b want %0b", j, done, (j == 2)); end
         $display("reenable j=%0d duty=%0d", j, duty_sel);
      end
   endtask

   // Retarget while holding: 200 -> 100 -> 50 -> 90
   task automatic test_retarget();
      int a_d [3] = '{200, 136, 100};
      int b_d [3] = '{100, 70, 50};
      int c_d [3] = '{50, 80, 90};
      cfg(1, 1, 64, 100);
      for (int j = 0; j < 3; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(a_d[j])) begin bad++; $display("FAIL retgt_100 j=%0d: got %0d want %0d", j, duty_sel, a_d[j]); end
      end
      step_in = 8'd30;
      target  = 8'd50;
      for (int j = 0; j < 3; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(b_d[j])) begin bad++; $display("FAIL retgt_50 j=%0d: got %0d want %0d", j, duty_sel, b_d[j]); end
         total++; if (done !== (j == 2))       begin bad++; $display("FAIL retgt_50_done j=%0d: got %0b want %0b", j, done, (j == 2)); end
         $display("retarget50 j=%0d duty=%0d", j, duty_sel);
      end
      target = 8'd90;
      for (int j = 0; j < 3; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(c_d[j])) begin bad++; $display("FAIL retgt_90 j=%0d: got %0d want %0d", j, duty_sel, c_d[j]); end
         total++; if (done !== (j == 2))       begin bad++; $display("FAIL retgt_90_done j=%0d: got %0b want %0b", j, done, (j == 2)); end
         $display("retarget90 j=%0d duty=%0d", j, duty_sel);
      end
   endtask

   // Reset mid-ramp, then zero config fields behave as one, then target 0
   task automatic test_reset_mid_ramp();
      reset_n = 1'b0;
      enable  = 1'b0;
      #2 reset_n = 1'b1;
      cfg(2, 1, 1, 50);
      enable = 1'b1;
      for (int j = 0; j <= 6; j++) cyc();
      total++; if (duty_sel !== 8'd3 || tick !== 1'b1) begin
         bad++; $display("FAIL mid_pre: duty=%0d tick=%0b want 3/1", duty_sel, tick);
      end
      #2 reset_n = 1'b0;
      #1;
      total++; if (duty_sel !== 8'd0 || pwr_en !== 1'b0 || done !== 1'b0 || idle !== 1'b1 || tick !== 1'b0) begin
         bad++; $display("FAIL mid_reset: duty=%0d en=%0b done=%0b idle=%0b tick=%0b want 0/0/0/1/0",
                         duty_sel, pwr_en, done, idle, tick);
      end
      enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         cyc();
         total++; if (idle !== 1'b1 || duty_sel !== 8'd0 || tick !== 1'b0) begin
            bad++; $display("FAIL mid_quiet j=%0d: idle=%0b duty=%0d tick=%0b want 1/0/0", j, idle, duty_sel, tick);
         end
      end
      cfg(0, 0, 0, 3);
      enable = 1'b1;
      for (int j = 0; j < 4; j++) begin
         cyc();
         total++; if (duty_sel !== 8'(j)) begin bad++; $display("FAIL zero_cfg j=%0d: got %0d want %0d", j, duty_sel, j); end
         total++; if (done !== (j == 3)) begin bad++; $display("FAIL zero_cfg_done j=%0d: got %0b want %0b", j, done, (j == 3)); end
         total++; if (idle !== 1'b0)     begin bad++; $display("FAIL zero_cfg_idle j=%0d: got %0b want 0", j, idle); end
         $display("zero_cfg j=%0d duty=%0d", j, duty_sel);
      end
   endtask

   // Target 0 while enabled holds at zero with the stage off, not idle
   task automatic test_target_zero();
      reset_n = 1'b0;
      enable  = 1'b0;
      #2 reset_n = 1'b1;
      cfg(1, 1, 1, 0);
      enable = 1'b1;
      cyc();
      total++; if (idle !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL tz_start: idle=%0b done=%0b want 0/0", idle, done); end
      cyc();
      total++; if (done !== 1'b1 || pwr_en !== 1'b0 || idle !== 1'b0 || duty_sel !== 8'd0) begin
         bad++; $display("FAIL tz_hold: done=%0b en=%0b idle=%0b duty=%0d want 1/0/0/0", done, pwr_en, idle, duty_sel);
      end
      enable = 1'b0;
      cyc();
      total++; if (done !== 1'b0 || idle !== 1'b0) begin bad++; $display("FAIL tz_stop: done=%0b idle=%0b want 0/0", done, idle); end
      cyc();
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL tz_idle: got %0b want 1", idle); end
      $display("target_zero idle=%0b", idle);
   endtask

   initial begin
      test_reset();
      test_slow_ramp();
      test_saturate();
      test_soft_stop();
      test_reenable();
      test_retarget();
      test_reset_mid_ramp();
      test_target_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
